// File: rtl/regbank_pkg.sv
// regbank_pkg
//  Shared defaults for the parametrised register bank: data width, register
//  count and address width, plus data/address typedefs at those defaults.
//  No ports; imported by regbank_param and regbank_rdport.
package regbank_pkg;

  localparam int DW_DEFAULT   = 9;
  localparam int NREG_DEFAULT = 10;
  localparam int AW_DEFAULT   = 4;

  typedef logic [DW_DEFAULT-1:0] data_t;
  typedef logic [AW_DEFAULT-1:0] addr_t;

endpackage

// File: rtl/regbank_rdport.sv
// regbank_rdport
//  One registered read port of the register bank: address range check,
//  write-to-read bypass compare and the output register for data and busy.
// Ports
//  clk       in   clock, rising edge
//  rst_n     in   asynchronous active-low reset
//  rd_en     in   load the output register this cycle
//  sr        in   read address
//  regs      in   flattened storage array, register i at [i*DW +: DW]
//  busy_nxt  in   next-state busy vector (same-cycle reserve/write applied)
//  wr_ok     in   a write to storage takes effect this cycle
//  dr        in   write address
//  din       in   write data
//  dsr       out  registered read data
//  busy      out  registered busy flag of sr
//  oor       out  combinational: out-of-range read attempted this cycle
module regbank_rdport
  import regbank_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [AW-1:0]      sr,
  input  logic [NREG*DW-1:0] regs,
  input  logic [NREG-1:0]    busy_nxt,
  input  logic               wr_ok,
  input  logic [AW-1:0]      dr,
  input  logic [DW-1:0]      din,
  output logic [DW-1:0]      dsr,
  output logic               busy,
  output logic               oor
);

  localparam logic [AW:0] NREG_A = (AW+1)'(NREG);

  logic          in_range;
  logic [DW-1:0] raw_data;
  logic          raw_busy;

  // Decode-style mux so an out-of-range address simply selects nothing
  always_comb begin
    in_range = ({1'b0, sr} < NREG_A);
    raw_data = '0;
    raw_busy = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (sr == AW'(i)) begin
        raw_data = regs[i*DW +: DW];
        raw_busy = busy_nxt[i];
      end
    end
    oor = rd_en & ~in_range;
  end

  // A write landing on the same register in the read cycle is forwarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsr  <= '0;
      busy <= 1'b0;
    end else if (rd_en) begin
      if (!in_range) begin
        dsr  <= '0;
        busy <= 1'b0;
      end else if (wr_ok && (dr == sr)) begin
        dsr  <= din;
        busy <= raw_busy;
      end else begin
        dsr  <= raw_data;
        busy <= raw_busy;
      end
    end
  end

endmodule

// File: rtl/regbank_param.sv
// regbank_param
//  NREG x DW register bank with one write port, two registered read ports,
//  write-to-read bypass and a per-register busy scoreboard for issue.
//  Optional feature macro: R0_ZERO_EN (register 0 hardwired to zero).
// Ports
//  clk       in   clock, rising edge
//  rst_n     in   asynchronous active-low reset
//  rd_en     in   sample both read ports this cycle
//  sr1/sr2   in   read addresses
//  dsr1/dsr2 out  registered read data
//  busy1/2   out  registered busy flags of sr1/sr2
//  rd_valid  out  read outputs valid this cycle
//  write     in   write strobe
//  dr        in   write address
//  din       in   write data
//  rsv_en    in   reserve (mark busy) register rsv_dr
//  rsv_dr    in   register to reserve
//  addr_err  out  sticky out-of-range address flag
module regbank_param
  import regbank_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_en,
  input  logic [AW-1:0] sr1,
  input  logic [AW-1:0] sr2,
  output logic [DW-1:0] dsr1,
  output logic [DW-1:0] dsr2,
  output logic          busy1,
  output logic          busy2,
  output logic          rd_valid,
  input  logic          write,
  input  logic [AW-1:0] dr,
  input  logic [DW-1:0] din,
  input  logic          rsv_en,
  input  logic [AW-1:0] rsv_dr,
  output logic          addr_err
);

  localparam logic [AW:0] NREG_A = (AW+1)'(NREG);

  logic [DW-1:0]      mem [NREG];
  logic [NREG*DW-1:0] regs_flat;
  logic [NREG-1:0]    busy_q;
  logic [NREG-1:0]    busy_nxt;

  logic wr_in_range;
  logic rsv_in_range;
  logic wr_ok;
  logic rsv_ok;
  logic wr_err;
  logic rsv_err;
  logic oor1;
  logic oor2;

  assign wr_in_range  = ({1'b0, dr} < NREG_A);
  assign rsv_in_range = ({1'b0, rsv_dr} < NREG_A);
  assign wr_err       = write & ~wr_in_range;
  assign rsv_err      = rsv_en & ~rsv_in_range;

`ifdef R0_ZERO_EN
  // Register 0 is constant zero: writes and reserves to it are silently dropped
  assign wr_ok  = write & wr_in_range & (dr != '0);
  assign rsv_ok = rsv_en & rsv_in_range & (rsv_dr != '0);
`else
  assign wr_ok  = write & wr_in_range;
  assign rsv_ok = rsv_en & rsv_in_range;
`endif

  // Reserve is applied after the write clear so a same-cycle reserve wins
  always_comb begin
    busy_nxt = busy_q;
    for (int i = 0; i < NREG; i++) begin
      if (wr_ok && (dr == AW'(i))) busy_nxt[i] = 1'b0;
      if (rsv_ok && (rsv_dr == AW'(i))) busy_nxt[i] = 1'b1;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NREG; i++) regs_flat[i*DW +: DW] = mem[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      busy_q   <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_ok && (dr == AW'(i))) mem[i] <= din;
      end
      busy_q   <= busy_nxt;
      rd_valid <= rd_en;
      addr_err <= addr_err | wr_err | rsv_err | oor1 | oor2;
    end
  end

  regbank_rdport #(.DW(DW), .NREG(NREG), .AW(AW)) u_rd1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .sr       (sr1),
    .regs     (regs_flat),
    .busy_nxt (busy_nxt),
    .wr_ok    (wr_ok),
    .dr       (dr),
    .din      (din),
    .dsr      (dsr1),
    .busy     (busy1),
    .oor      (oor1)
  );

  regbank_rdport #(.DW(DW), .NREG(NREG), .AW(AW)) u_rd2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .sr       (sr2),
    .regs     (regs_flat),
    .busy_nxt (busy_nxt),
    .wr_ok    (wr_ok),
    .dr       (dr),
    .din      (din),
    .dsr      (dsr2),
    .busy     (busy2),
    .oor      (oor2)
  );

endmodule

// File: tb/tb_regbank_param.sv
// tb_regbank_param
//  Self-checking bench for regbank_param: a table of stimulus rows with
//  hand-derived expected read results pushed to a scoreboard queue when a
//  read is issued and popped one cycle later, plus hand-written reset and
//  address-error sequences. Honours R0_ZERO_EN for register 0 expectations.
module tb_regbank_param;
  import regbank_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  rd_en;
  addr_t sr1, sr2;
  data_t dsr1, dsr2;
  logic  busy1, busy2, rd_valid;
  logic  write;
  addr_t dr;
  data_t din;
  logic  rsv_en;
  addr_t rsv_dr;
  logic  addr_err;

  regbank_param dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_en    (rd_en),
    .sr1      (sr1),
    .sr2      (sr2),
    .dsr1     (dsr1),
    .dsr2     (dsr2),
    .busy1    (busy1),
    .busy2    (busy2),
    .rd_valid (rd_valid),
    .write    (write),
    .dr       (dr),
    .din      (din),
    .rsv_en   (rsv_en),
    .rsv_dr   (rsv_dr),
    .addr_err (addr_err)
  );

  always #5 clk = ~clk;

`ifdef R0_ZERO_EN
  localparam data_t R0_VAL  = 9'h000;
  localparam logic  R0_BUSY = 1'b0;
`else
  localparam data_t R0_VAL  = 9'h1FF;
  localparam logic  R0_BUSY = 1'b1;
`endif

  typedef struct {
    logic  write;
    addr_t dr;
    data_t din;
    logic  rsv_en;
    addr_t rsv_dr;
    logic  rd_en;
    addr_t sr1;
    addr_t sr2;
    data_t e1;
    data_t e2;
    logic  eb1;
    logic  eb2;
    logic  eerr;
  } vec_t;

  typedef struct {
    data_t e1;
    data_t e2;
    logic  eb1;
    logic  eb2;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mkv(input logic w, input addr_t d, input data_t di,
                               input logic rv, input addr_t rd, input logic re,
                               input addr_t s1, input addr_t s2,
                               input data_t e1, input data_t e2,
                               input logic b1, input logic b2, input logic er);
    vec_t v;
    v.write = w;  v.dr = d;  v.din = di;
    v.rsv_en = rv; v.rsv_dr = rd;
    v.rd_en = re; v.sr1 = s1; v.sr2 = s2;
    v.e1 = e1; v.e2 = e2; v.eb1 = b1; v.eb2 = b2; v.eerr = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    write = v.write;  dr = v.dr;  din = v.din;
    rsv_en = v.rsv_en; rsv_dr = v.rsv_dr;
    rd_en = v.rd_en;  sr1 = v.sr1; sr2 = v.sr2;
    if (v.rd_en) begin
      e.e1 = v.e1; e.e2 = v.e2; e.eb1 = v.eb1; e.eb2 = v.eb2;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    exp_t e;
    chk({tag, " rd_valid"}, 9'(rd_valid), 9'(v.rd_en));
    if (v.rd_en) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL %s scoreboard: got empty queue expected one entry", tag);
      end else begin
        e = sb.pop_front();
        chk({tag, " dsr1"}, dsr1, e.e1);
        chk({tag, " dsr2"}, dsr2, e.e2);
        chk({tag, " busy1"}, 9'(busy1), 9'(e.eb1));
        chk({tag, " busy2"}, 9'(busy2), 9'(e.eb2));
      end
    end
    chk({tag, " addr_err"}, 9'(addr_err), 9'(v.eerr));
  endtask

  task automatic checkReset(input string tag);
    chk({tag, " dsr1"}, dsr1, 9'h000);
    chk({tag, " dsr2"}, dsr2, 9'h000);
    chk({tag, " busy1"}, 9'(busy1), 9'h000);
    chk({tag, " busy2"}, 9'(busy2), 9'h000);
    chk({tag, " rd_valid"}, 9'(rd_valid), 9'h000);
    chk({tag, " addr_err"}, 9'(addr_err), 9'h000);
  endtask

  task automatic clearInputs();
    write = 1'b0; dr = '0; din = '0;
    rsv_en = 1'b0; rsv_dr = '0;
    rd_en = 1'b0; sr1 = '0; sr2 = '0;
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    clearInputs();
    sb.delete();
    #1;
    checkReset(tag);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic runRow(input vec_t v, input string tag);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput(v, tag);
  endtask

  initial begin
    //            w  dr    din     rv rdr  re s1  s2     e1      e2      b1 b2       er
    tbl.push_back(mkv(0, 0,  9'h000, 0, 0,  1, 3,  9,  9'h000, 9'h000, 0, 0,       0));
    tbl.push_back(mkv(1, 5,  9'h1A5, 0, 0,  0, 0,  0,  9'h000, 9'h000, 0, 0,       0));
    tbl.push_back(mkv(0, 0,  9'h000, 0, 0,  1, 5,  3,  9'h1A5, 9'h000, 0, 0,       0));
    tbl.push_back(mkv(1, 2,  9'h0F0, 0, 0,  1, 2,  2,  9'h0F0, 9'h0F0, 0, 0,       0));
    tbl.push_back(mkv(0, 0,  9'h000, 1, 7,  0, 0,  0,  9'h000, 9'h000, 0, 0,       0));
    tbl.push_back(mkv(0, 0,  9'h000, 0, 0,  1, 7,  5,  9'h000, 9'h1A5, 1, 0,       0));
    tbl.push_back(mkv(1, 7,  9'h033, 0, 0,  1, 7,  7,  9'h033, 9'h033, 0, 0,       0));
    tbl.push_back(mkv(0, 0,  9'h000, 0, 0,  1, 7,  2,  9'h033, 9'h0F0, 0, 0,       0));
    tbl.push_back(mkv(1, 7,  9'h044, 1, 7,  1, 7,  7,  9'h044, 9'h044, 1, 1,       0));
    tbl.push_back(mkv(0, 0,  9'h000, 0, 0,  1, 7,  4,  9'h044, 9'h000, 1, 0,       0));
    tbl.push_back(mkv(0, 0,  9'h000, 1, 3,  1, 3,  3,  9'h000, 9'h000, 1, 1,       0));
    tbl.push_back(mkv(1, 0,  9'h1FF, 0, 0,  1, 0,  0,  R0_VAL, R0_VAL, 0, 0,       0));
    tbl.push_back(mkv(0, 0,  9'h000, 1, 0,  1, 0,  1,  R0_VAL, 9'h000, R0_BUSY, 0, 0));
    tbl.push_back(mkv(1, 12, 9'h055, 0, 0,  0, 0,  0,  9'h000, 9'h000, 0, 0,       1));
    tbl.push_back(mkv(0, 0,  9'h000, 0, 0,  1, 4,  15, 9'h000, 9'h000, 0, 0,       1));
    tbl.push_back(mkv(1, 3,  9'h0AB, 0, 0,  1, 3,  9,  9'h0AB, 9'h000, 0, 0,       1));
    tbl.push_back(mkv(1, 9,  9'h111, 0, 0,  1, 9,  8,  9'h111, 9'h000, 0, 0,       1));
    tbl.push_back(mkv(0, 0,  9'h000, 0, 0,  1, 9,  3,  9'h111, 9'h0AB, 0, 0,       1));

    $display("[TB] start");
    doReset("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      runRow(tbl[i], $sformatf("row%0d", i));
    end

    // Reset asserted between the edges of a write: outputs clear at once,
    // and the write must not land.
    clearInputs();
    write = 1'b1; dr = 4'd5; din = 9'h0AA;
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("midrst");
    @(posedge clk);
    #1;
    clearInputs();
    rst_n = 1'b1;
    runRow(mkv(0, 0, 9'h000, 0, 0, 1, 5, 9, 9'h000, 9'h000, 0, 0, 0), "postrst");

    // Out-of-range reserve is ignored but flags addr_err
    runRow(mkv(0, 0, 9'h000, 1, 11, 0, 0, 0, 9'h000, 9'h000, 0, 0, 1), "rsv_oor");
    runRow(mkv(0, 0, 9'h000, 0, 0, 1, 11, 2, 9'h000, 9'h000, 0, 0, 1), "rsv_oor_rd");

    // Out-of-range read on port 1 alone flags addr_err
    doReset("reset2");
    runRow(mkv(0, 0, 9'h000, 0, 0, 1, 10, 2, 9'h000, 9'h000, 0, 0, 1), "rd1_oor");

    // Out-of-range read on port 2 alone flags addr_err
    doReset("reset3");
    runRow(mkv(0, 0, 9'h000, 0, 0, 1, 1, 14, 9'h000, 9'h000, 0, 0, 1), "rd2_oor");

    // Write to first invalid address flags addr_err and changes nothing
    doReset("reset4");
    runRow(mkv(1, 10, 9'h077, 0, 0, 0, 0, 0, 9'h000, 9'h000, 0, 0, 1), "wr_oor");
    runRow(mkv(0, 0, 9'h000, 0, 0, 1, 2, 8, 9'h000, 9'h000, 0, 0, 1), "wr_oor_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
